// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDW   = $clog2(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot_from_id(input logic [IDW-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority encoder: first eligible requester after last_id wins.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDW-1:0]   last_id,
    output logic [IDW-1:0]   win_id,
    output logic             win_valid
);
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] rot;
    logic [IDW-1:0]   cand [N_REQ];

    assign elig = req & ~mask;

    // Candidate indices wrap naturally through the IDW-bit addition.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign cand[gi] = last_id + IDW'(gi + 1);
            assign rot[gi]  = elig[cand[gi]];
        end
    endgenerate

    always_comb begin
        win_valid = |rot;
        win_id    = cand[0];
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_id = cand[i];
            end
        end
    end
endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter with grant hold, release handshake and hold-time watchdog.
module rr_arb4_ctrl
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);
    state_t           state_reg, state_next;
    logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
    logic [IDW-1:0]   last_id_reg, last_id_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [IDW-1:0]   gnt_id_reg, gnt_id_next;
    logic             gnt_valid_reg, gnt_valid_next;
    logic             timeout_reg, timeout_next;

    logic [IDW-1:0]   pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic [IDW-1:0]   win_id;
    logic             win_valid;
    logic             wd_hit;
    logic             withdraw;
    logic             release_now;

    // While granted, the pick already sees the post-release pointer and masks the holder.
    assign pick_ptr  = (state_reg == GRANT) ? gnt_id_reg : last_id_reg;
    assign pick_mask = (state_reg == GRANT) ? onehot_from_id(gnt_id_reg) : '0;

    rr_pick4 u_pick (
        .req       (req),
        .mask      (pick_mask),
        .last_id   (pick_ptr),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    generate
        if (MAX_HOLD != 0) begin : g_wd
            assign wd_hit = (hold_cnt_reg == HW'(MAX_HOLD - 1));
        end else begin : g_no_wd
            assign wd_hit = 1'b0;
        end
    endgenerate

    assign withdraw    = ~req[gnt_id_reg];
    assign release_now = done | withdraw | wd_hit;

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        last_id_next   = last_id_reg;
        gnt_next       = gnt_reg;
        gnt_id_next    = gnt_id_reg;
        gnt_valid_next = gnt_valid_reg;
        timeout_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt_next       = '0;
                gnt_id_next    = '0;
                gnt_valid_next = 1'b0;
                hold_cnt_next  = '0;
                if (win_valid) begin
                    state_next     = GRANT;
                    gnt_next       = onehot_from_id(win_id);
                    gnt_id_next    = win_id;
                    gnt_valid_next = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_id_next  = gnt_id_reg;
                    hold_cnt_next = '0;
                    // A cooperative release in the same cycle hides the watchdog.
                    timeout_next  = wd_hit & ~done & ~withdraw;
                    if (win_valid) begin
                        gnt_next    = onehot_from_id(win_id);
                        gnt_id_next = win_id;
                    end else begin
                        state_next     = IDLE;
                        gnt_next       = '0;
                        gnt_id_next    = '0;
                        gnt_valid_next = 1'b0;
                    end
                end else if (hold_cnt_reg != HW'(MAX_HOLD)) begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
            default: begin
                state_next     = IDLE;
                gnt_next       = '0;
                gnt_id_next    = '0;
                gnt_valid_next = 1'b0;
                hold_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hold_cnt_reg  <= '0;
            last_id_reg   <= IDW'(N_REQ - 1);
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            last_id_reg   <= last_id_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            gnt_valid_reg <= gnt_valid_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = gnt_valid_reg;
    assign timeout   = timeout_reg;
endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Scoreboard bench for rr_arb4_ctrl: directed per-cycle vectors, expected outputs queued and checked by a monitor.
module tb_rr_arb4_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    failures;

    rr_arb4_ctrl #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string nm, input exp_t e);
        logic bad;
        checks++;
        bad = (gnt !== e.gnt) || (gnt_valid !== e.valid) || (timeout !== e.to)
              || (e.valid && (gnt_id !== e.id));
        if (bad) begin
            failures++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
                     nm, gnt, gnt_id, gnt_valid, timeout, e.gnt, e.id, e.valid, e.to);
        end else begin
            $display("ok   %s: gnt=%b id=%0d valid=%b timeout=%b", nm, gnt, gnt_id, gnt_valid, timeout);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input string nm, input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic et);
        exp_t e;
        @(negedge clk);
        req     = r;
        done    = d;
        e.gnt   = eg;
        e.valid = |eg;
        e.id    = id_of(eg);
        e.to    = et;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_zero(input string nm);
        exp_t e;
        e.gnt = 4'b0; e.id = 2'd0; e.valid = 1'b0; e.to = 1'b0;
        check(nm, e);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, e);
            end
        end
    end

    initial begin : global_limit
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0;
        done     = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;

        // Idle with no requests; done while idle is ignored.
        for (int i = 0; i < 5; i++) step("idle_noreq", 4'b0000, 1'b0, 4'b0000, 1'b0);
        step("idle_done", 4'b0000, 1'b1, 4'b0000, 1'b0);

        // All requesting, done every third cycle: 0,1,2,3,0 back to back.
        step("rr_g0", 4'b1111, 1'b0, 4'b0001, 1'b0);
        step("rr_h0", 4'b1111, 1'b0, 4'b0001, 1'b0);
        step("rr_h0", 4'b1111, 1'b0, 4'b0001, 1'b0);
        step("rr_g1", 4'b1111, 1'b1, 4'b0010, 1'b0);
        step("rr_h1", 4'b1111, 1'b0, 4'b0010, 1'b0);
        step("rr_h1", 4'b1111, 1'b0, 4'b0010, 1'b0);
        step("rr_g2", 4'b1111, 1'b1, 4'b0100, 1'b0);
        step("rr_h2", 4'b1111, 1'b0, 4'b0100, 1'b0);
        step("rr_h2", 4'b1111, 1'b0, 4'b0100, 1'b0);
        step("rr_g3", 4'b1111, 1'b1, 4'b1000, 1'b0);
        step("rr_h3", 4'b1111, 1'b0, 4'b1000, 1'b0);
        step("rr_h3", 4'b1111, 1'b0, 4'b1000, 1'b0);
        step("rr_g0_wrap", 4'b1111, 1'b1, 4'b0001, 1'b0);
        step("rr_withdraw", 4'b0000, 1'b0, 4'b0000, 1'b0);
        step("rr_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Lone requester: release, one idle cycle, regrant.
        step("solo_g2", 4'b0100, 1'b0, 4'b0100, 1'b0);
        step("solo_rel", 4'b0100, 1'b1, 4'b0000, 1'b0);
        step("solo_regrant", 4'b0100, 1'b0, 4'b0100, 1'b0);
        step("solo_drop", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Watchdog: grant 0 held 16 cycles, then forced to 1 with a timeout pulse.
        step("wd_g0", 4'b0011, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 15; i++) step("wd_hold0", 4'b0011, 1'b0, 4'b0001, 1'b0);
        step("wd_timeout", 4'b0011, 1'b0, 4'b0010, 1'b1);
        // done coinciding with the watchdog limit is a normal release.
        for (int i = 0; i < 15; i++) step("wd_hold1", 4'b0011, 1'b0, 4'b0010, 1'b0);
        step("wd_done_limit", 4'b0011, 1'b1, 4'b0001, 1'b0);
        step("wd_drop", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Holder 2 withdraws with 0 and 3 pending: 3 comes first after 2.
        step("wdr_g2", 4'b0100, 1'b0, 4'b0100, 1'b0);
        step("wdr_hold2", 4'b1101, 1'b0, 4'b0100, 1'b0);
        step("wdr_g3", 4'b1001, 1'b0, 4'b1000, 1'b0);
        step("wdr_drop", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a grant.
        step("mid_g0", 4'b0001, 1'b0, 4'b0001, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_clear");
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_g3", 4'b1000, 1'b0, 4'b1000, 1'b0);
        step("post_rst_drop", 4'b0000, 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
